// File: rtl/adc_read_scheduler_pkg.sv
// Shared definitions for the ADC read scheduler: FSM encoding and default timing.
package adc_read_scheduler_pkg;

    localparam int unsigned ADC_WIDTH = 12;

    // Defaults sized for the standard ADC comm rate: CAL_WAIT covers 32+2 sclk periods
    // with margin, TIMEOUT is twice that.
    localparam int unsigned DEF_CAL_WAIT       = 2048;
    localparam int unsigned DEF_TIMEOUT        = 4096;
    localparam int unsigned DEF_RECAL_INTERVAL = 1024;

    typedef enum logic [2:0] {
        StBoot      = 3'd0,
        StIdle      = 3'd1,
        StIssue     = 3'd2,
        StWait      = 3'd3,
        StDeliver   = 3'd4,
        StRecal     = 3'd5,
        StRecalWait = 3'd6
    } state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_read_scheduler_rr_arbiter.sv
// Round-robin search: first set request at or after the pointer, wrapping modulo NUM_REQ.
module adc_read_scheduler_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;

    // Scan NUM_REQ positions starting at the pointer; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            logic [IDX_W-1:0] j;
            j = IDX_W'((32'(pointer) + i) % NUM_REQ);
            if (!found && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = j;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_read_scheduler.sv
// Shares one serial ADC between NUM_REQ requesters (round-robin), sequences boot
// calibration wait, periodic and on-demand recalibration, and a conversion watchdog.
module adc_read_scheduler
    import adc_read_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned RECAL_INTERVAL = DEF_RECAL_INTERVAL,
    parameter int unsigned CAL_WAIT       = DEF_CAL_WAIT,
    parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 force_recal,
    input  logic                 err_clear,
    output logic [NUM_REQ-1:0]   grant,
    output logic [ADC_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 adc_read,
    output logic                 adc_recalibrate,
    input  logic                 adc_read_done,
    input  logic [ADC_WIDTH-1:0] adc_value
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMR_W = $clog2(max2(CAL_WAIT, TIMEOUT) + 1);
    localparam int unsigned CNT_W = (RECAL_INTERVAL > 0) ? $clog2(RECAL_INTERVAL + 1) : 1;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [ADC_WIDTH-1:0]   result_q, result_d;
    logic                   valid_q, valid_d;
    logic                   read_q, read_d;
    logic                   recal_q, recal_d;
    logic                   err_q, err_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic                   done_q;

    logic                   done_rise;
    logic                   auto_hit;
    logic                   recal_req;
    logic                   err_set;
    logic                   pending_clr;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic [IDX_W-1:0]       idx_next;

    adc_read_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req),
        .pointer   (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign done_rise = adc_read_done & ~done_q;
    assign auto_hit  = (RECAL_INTERVAL != 0) && (cnt_q == CNT_W'(RECAL_INTERVAL));
    // A pulse arriving in IDLE itself is honoured immediately, not one cycle later.
    assign recal_req = pending_q | force_recal | auto_hit;
    assign idx_next  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    // Next-state and registered-output logic for the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        result_d    = result_q;
        valid_d     = 1'b0;
        read_d      = read_q;
        recal_d     = recal_q;
        tmr_d       = tmr_q;
        cnt_d       = cnt_q;
        err_set     = 1'b0;
        pending_clr = 1'b0;

        unique case (state_q)
            StBoot: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(CAL_WAIT - 1)) begin
                    tmr_d   = '0;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (recal_req) begin
                    state_d = StRecal;
                end else if (|req) begin
                    grant_d = arb_grant;
                    idx_d   = arb_idx;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                read_d  = 1'b1;
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (done_rise) begin
                    result_d = adc_value;
                    read_d   = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = StDeliver;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    // Abort: skip past the stalled requester so others are not starved.
                    read_d  = 1'b0;
                    err_set = 1'b1;
                    grant_d = '0;
                    ptr_d   = idx_next;
                    state_d = StIdle;
                end
            end
            StDeliver: begin
                grant_d = '0;
                ptr_d   = idx_next;
                if ((RECAL_INTERVAL != 0) && !auto_hit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = StIdle;
            end
            StRecal: begin
                recal_d = 1'b1;
                tmr_d   = '0;
                state_d = StRecalWait;
            end
            StRecalWait: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(CAL_WAIT - 1)) begin
                    recal_d     = 1'b0;
                    tmr_d       = '0;
                    cnt_d       = '0;
                    pending_clr = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        // Timeout set wins over a same-cycle clear.
        err_d = err_set ? 1'b1 : (err_clear ? 1'b0 : err_q);

        // A pulse coinciding with the end of a recal is kept for the next one.
        pending_d = pending_clr ? force_recal : (pending_q | force_recal | auto_hit);
    end

    // State and output registers; async active-low reset restarts in BOOT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StBoot;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            read_q    <= 1'b0;
            recal_q   <= 1'b0;
            err_q     <= 1'b0;
            tmr_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            read_q    <= read_d;
            recal_q   <= recal_d;
            err_q     <= err_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            done_q    <= adc_read_done;
        end
    end

    assign grant           = grant_q;
    assign result          = result_q;
    assign result_valid    = valid_q;
    assign busy            = (state_q != StIdle);
    assign timeout_err     = err_q;
    assign adc_read        = read_q;
    assign adc_recalibrate = recal_q;

endmodule

// File: tb/tb_adc_read_scheduler.sv
// Scoreboard bench for adc_read_scheduler with a behavioural ADC model.
module tb_adc_read_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned RI   = 3;
    localparam int unsigned CW   = 100;
    localparam int unsigned TO   = 200;
    localparam int          LAT  = 12;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [11:0] val;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req;
    logic            force_recal;
    logic            err_clear;
    logic [NREQ-1:0] grant;
    logic [11:0]     result;
    logic            result_valid;
    logic            busy;
    logic            timeout_err;
    logic            adc_read;
    logic            adc_recalibrate;
    logic            adc_read_done;
    logic [11:0]     adc_value;

    adc_read_scheduler #(
        .NUM_REQ        (NREQ),
        .RECAL_INTERVAL (RI),
        .CAL_WAIT       (CW),
        .TIMEOUT        (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .force_recal     (force_recal),
        .err_clear       (err_clear),
        .grant           (grant),
        .result          (result),
        .result_valid    (result_valid),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .adc_read        (adc_read),
        .adc_recalibrate (adc_recalibrate),
        .adc_read_done   (adc_read_done),
        .adc_value       (adc_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [11:0] vals[$];
    int n_checks, n_fail;
    int n_valid, n_rd_rise, n_recal_rise, recal_hi, valid_at_recal, rd_at_recal;
    logic rd_prev, recal_prev, auto_drop, hang, responding;
    int lat_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_conv(input logic [3:0] g, input logic [11:0] v);
        exp_t e;
        e.gnt = g;
        e.val = v;
        vals.push_back(v);
        sb.push_back(e);
    endtask

    // One clock: sample at negedge, score valids, then update the ADC model.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (result_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("result", 32'(result), 32'(e.val));
                check_eq("grant_on_valid", 32'(grant), 32'(e.gnt));
            end
            if (auto_drop) req = req & ~grant;
        end
        if (adc_read && !rd_prev) n_rd_rise++;
        if (adc_recalibrate && !recal_prev) begin
            n_recal_rise++;
            valid_at_recal = n_valid;
            rd_at_recal    = n_rd_rise;
        end
        if (adc_recalibrate) recal_hi++;
        rd_prev    = adc_read;
        recal_prev = adc_recalibrate;
        if (responding) begin
            if (!adc_read) begin
                adc_read_done = 1'b0;
                responding    = 1'b0;
                lat_cnt       = 0;
            end
        end else if (adc_read && !hang) begin
            lat_cnt++;
            if (lat_cnt >= LAT && vals.size() > 0) begin
                adc_value     = vals.pop_front();
                adc_read_done = 1'b1;
                responding    = 1'b1;
            end
        end else if (!adc_read) begin
            lat_cnt = 0;
        end
    endtask

    task automatic clear_model();
        adc_read_done = 1'b0;
        responding    = 1'b0;
        lat_cnt       = 0;
        n_valid       = 0;
        n_rd_rise     = 0;
        n_recal_rise  = 0;
        recal_hi      = 0;
        valid_at_recal = -1;
        rd_at_recal    = -1;
    endtask

    task automatic reset_dut();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        reset = 1'b0;
        req = '0; force_recal = 1'b0; err_clear = 1'b0; hang = 1'b0; auto_drop = 1'b1;
        vals.delete();
        sb.delete();
        step();
        step();
        clear_model();
        reset = 1'b1;
    endtask

    task automatic wait_valids(input int target, input int bound);
        int n = 0;
        while (n_valid < target && n < bound) begin
            step();
            n++;
        end
        check_eq("valid_count", 32'(n_valid), 32'(target));
    endtask

    task automatic wait_read(input logic level, input int bound, output int n);
        n = 0;
        while (adc_read !== level && n < bound) begin
            step();
            n++;
        end
        check_eq("read_level", 32'(adc_read), 32'(level));
    endtask

    initial begin
        int n, first_g, hi;
        n_checks = 0; n_fail = 0;
        rd_prev = 1'b0; recal_prev = 1'b0;
        adc_value = '0;
        reset = 1'b0; req = '0; force_recal = 1'b0; err_clear = 1'b0;
        hang = 1'b0; auto_drop = 1'b1;
        clear_model();
        step();
        step();
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_read", 32'(adc_read), 32'd0);
        check_eq("rst_recal", 32'(adc_recalibrate), 32'd0);
        check_eq("rst_err", 32'(timeout_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);

        // Boot: no read during CAL_WAIT, grant one cycle before adc_read.
        req = 4'b0001;
        expect_conv(4'b0001, 12'h5A5);
        reset = 1'b1;
        n = 0; first_g = 0;
        while (!adc_read && n < int'(CW) + 50) begin
            step();
            n++;
            if (grant != 0 && first_g == 0) first_g = n;
        end
        check_eq("boot_read_cycle", 32'(n), 32'(CW + 2));
        check_eq("boot_grant_cycle", 32'(first_g), 32'(CW + 1));
        check_eq("boot_grant", 32'(grant), 32'b0001);
        wait_valids(1, 100);
        step(); step(); step();
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Round-robin with all requests held; auto recal after the third result.
        reset_dut();
        auto_drop = 1'b0;
        req = 4'b1111;
        expect_conv(4'b0001, 12'h123);
        expect_conv(4'b0010, 12'h456);
        expect_conv(4'b0100, 12'h789);
        expect_conv(4'b1000, 12'hABC);
        expect_conv(4'b0001, 12'hDEF);
        wait_valids(5, 2000);
        req = '0;
        step(); step();
        check_eq("auto_recal_count", 32'(n_recal_rise), 32'd1);
        check_eq("auto_recal_after_valid", 32'(valid_at_recal), 32'd3);
        check_eq("auto_recal_before_read4", 32'(rd_at_recal), 32'd3);
        check_eq("auto_recal_len", 32'(recal_hi), 32'(CW));

        // Timeout: requester 0 hangs, requester 1 is served next, err is sticky.
        reset_dut();
        req = 4'b0011;
        hang = 1'b1;
        wait_read(1'b1, CW + 20, n);
        hi = 1;
        step();
        while (adc_read && hi < int'(TO) + 20) begin
            hi++;
            step();
        end
        check_eq("to_read_len", 32'(hi), 32'(TO));
        check_eq("to_err", 32'(timeout_err), 32'd1);
        check_eq("to_grant", 32'(grant), 32'd0);
        check_eq("to_no_valid", 32'(n_valid), 32'd0);
        hang = 1'b0;
        expect_conv(4'b0010, 12'h321);
        expect_conv(4'b0001, 12'h0F0);
        wait_valids(2, 300);
        check_eq("to_err_sticky", 32'(timeout_err), 32'd1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check_eq("to_err_cleared", 32'(timeout_err), 32'd0);

        // force_recal during WAIT: delivery first, then exactly one recal, then next grant.
        reset_dut();
        req = 4'b0001;
        expect_conv(4'b0001, 12'h111);
        wait_read(1'b1, CW + 20, n);
        step(); step();
        force_recal = 1'b1;
        step();
        force_recal = 1'b0;
        step(); step();
        force_recal = 1'b1;
        step();
        force_recal = 1'b0;
        req = req | 4'b0010;
        expect_conv(4'b0010, 12'h222);
        wait_valids(2, 1000);
        step(); step();
        check_eq("force_recal_count", 32'(n_recal_rise), 32'd1);
        check_eq("force_recal_after_valid", 32'(valid_at_recal), 32'd1);
        check_eq("force_recal_before_read2", 32'(rd_at_recal), 32'd1);

        // Async reset in WAIT: outputs drop without a clock edge, then a fresh boot.
        reset_dut();
        req = 4'b0001;
        hang = 1'b1;
        wait_read(1'b1, CW + 20, n);
        step(); step(); step();
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_read", 32'(adc_read), 32'd0);
        check_eq("async_grant", 32'(grant), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd1);
        step();
        clear_model();
        reset = 1'b1;
        wait_read(1'b1, CW + 50, n);
        check_eq("reboot_read_cycle", 32'(n), 32'(CW + 2));
        hang = 1'b0;
        expect_conv(4'b0001, 12'hC3C);
        wait_valids(1, 100);
        step(); step();
        check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_read_scheduler.md
Name: adc_read_scheduler

Overview:
- Shares the single serial ADC front-end (12-bit, read/read_done handshake, recalibrate input) between NUM_REQ requesters using round-robin arbitration.
- Sequences the ADC's boot calibration wait, periodic recalibration every RECAL_INTERVAL conversions, and on-demand recalibration.
- Guards every conversion with a timeout watchdog.
- Sits between the control-loop sampling logic and the ADC block, in the system clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- RECAL_INTERVAL, 1024, completed conversions between automatic recalibrations; 0 disables auto recal.
- CAL_WAIT, 2048, clk cycles to wait after asserting recalibrate or leaving reset; must cover 32+2 ADC sclk periods.
- TIMEOUT, 4096, clk cycles allowed from adc_read assertion to adc_read_done before abort.

Ports:
- clk  in  1  system clock (same clock that drives the ADC's divider).
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; held until own result_valid.
- force_recal  in  1  single-cycle pulse requesting recalibration.
- err_clear  in  1  clears timeout_err.
- grant  out  NUM_REQ  one-hot owner of the in-flight conversion; 0 when none.
- result  out  12  converted value, registered.
- result_valid  out  1  one-cycle pulse; result belongs to requester flagged in grant this cycle.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky, set on conversion timeout.
- adc_read  out  1  to ADC read.
- adc_recalibrate  out  1  to ADC recalibrate.
- adc_read_done  in  1  from ADC read_done (level, lasts >= 1 sclk period).
- adc_value  in  12  from ADC value.

Behaviour:
- Reset (reset=0, async) values: state=BOOT, grant=0, result=0, result_valid=0, adc_read=0, adc_recalibrate=0, timeout_err=0, wait counter=0, conversion counter=0, RR pointer=0.
- Internal done_rise = adc_read_done & ~done_q; done_q is registered, reset 0. All handshake decisions use done_rise, never the level.
- States:
  - BOOT: count CAL_WAIT cycles (ADC self-calibrates after its reset) -> IDLE.
  - IDLE: priority is recal_pending first, then requests.
    - recal_pending set by force_recal, or by the conversion counter reaching RECAL_INTERVAL. If pending -> RECAL.
    - Else if any req: grant the first set bit at or after pointer, wrapping modulo NUM_REQ -> ISSUE.
  - ISSUE: adc_read=1, timer cleared -> WAIT.
  - WAIT: adc_read held 1; timer increments.
    - done_rise: capture adc_value into result, drop adc_read, -> DELIVER.
    - Timer reaches TIMEOUT-1 first: adc_read=0, timeout_err=1, grant=0, no result_valid -> IDLE. Pointer still advances past the aborted requester.
  - DELIVER: result_valid=1 for exactly 1 cycle with grant still set; pointer <= granted index+1 (mod NUM_REQ); conversion counter++ -> IDLE (grant=0 on entry).
  - RECAL: adc_recalibrate=1, timer cleared -> RECAL_WAIT.
  - RECAL_WAIT: adc_recalibrate held for CAL_WAIT cycles, then 0; clear recal_pending and conversion counter -> IDLE.
- Latency: req to adc_read is 2 clk from IDLE. done_rise to result_valid is 1 clk. IDLE is occupied for at least 1 cycle between conversions.
- The result is delivered even if the owner dropped req mid-flight. Requesters must ignore unexpected valids.
- force_recal arriving during WAIT or BOOT is latched in recal_pending and serviced at the next IDLE. Further force_recal pulses while pending are absorbed.
- Auto recal and force_recal in the same cycle cause one recalibration only.
- err_clear and a timeout in the same cycle: set wins.
- Conversion counter saturates at RECAL_INTERVAL; width $clog2(RECAL_INTERVAL+1).
- Reset mid-conversion: outputs go to reset values immediately; restart in BOOT.

Decomposition:
- Shared header (ADC.vh): state encodings (BOOT, IDLE, ISSUE, WAIT, DELIVER, RECAL, RECAL_WAIT as 3-bit constants) and default timing constants for CAL_WAIT and TIMEOUT per COMM_RATE.
- One sub-module, rr_arbiter: parameterised NUM_REQ. Inputs: req, pointer. Outputs: one-hot grant and its index. Combinational search, registered in the parent.

Test Plan:
- Boot: release reset; adc_read must stay 0 for 2048 cycles. With req=4'b0001, grant=0001 appears and adc_read rises 2 cycles after BOOT exits.
- Round-robin: req=4'b1111 held, ADC model returns 0x123, 0x456, 0x789, 0xABC. Grants must come in order 0001, 0010, 0100, 1000, 0001, with result matching each value on its result_valid pulse.
- Timeout: ADC model never asserts read_done. At cycle TIMEOUT: adc_read=0, timeout_err=1, no result_valid. Next requester is granted. err_clear returns timeout_err to 0.
- Auto recal: RECAL_INTERVAL=3, req=0001 held. After 3rd result_valid, adc_recalibrate=1 for CAL_WAIT cycles before the 4th adc_read.
- force_recal during WAIT: the current conversion completes and delivers. Then adc_recalibrate asserts before any further grant. A second pulse while pending yields only one recal.
- Async reset in WAIT: reset=0 mid-conversion forces adc_read=0, grant=0 without a clock edge. Release re-enters BOOT.
